// File: rtl/rob_sn_alloc.sv
// rob_sn_alloc: hands out ROB sequence numbers in program order and reclaims them in order on retire.
// Optional macro ROB_SN_ALLOC_BYPASS_EN: while full, a same-cycle retire frees its slot for an immediate grant.
module rob_sn_alloc #(
   parameter int p_depth    = 8,
   parameter int p_ptrwidth = $clog2(p_depth)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  alloc_req,
   output logic                  alloc_gnt,
   output logic [p_ptrwidth-1:0] alloc_sn,
   input  logic                  release_en,
   output logic [p_ptrwidth-1:0] release_sn,
   output logic [p_ptrwidth:0]   count,
   output logic                  empty,
   output logic                  full,
   input  logic                  drain_req,
   output logic                  drain_done
);

   typedef enum logic [1:0] {RUN, DRAIN, DONE} state_t;

   state_t                state, state_nxt;
   logic [p_ptrwidth-1:0] alloc_ptr, rel_ptr;
   logic                  rel_valid;
   logic                  can_issue;

   assign empty      = (count == '0);
   assign full       = (count == (p_ptrwidth+1)'(p_depth));
   assign rel_valid  = release_en & ~empty;
   assign can_issue  = alloc_req & (state == RUN);
   assign alloc_sn   = alloc_ptr;
   assign release_sn = rel_ptr;
   assign drain_done = (state == DONE);

`ifdef ROB_SN_ALLOC_BYPASS_EN
   // While full, a valid release in the same cycle hands its slot straight to the requester.
   assign alloc_gnt = can_issue & (~full | rel_valid);
`else
   assign alloc_gnt = can_issue & ~full;
`endif

   // Pointers wrap naturally at p_depth because p_depth is a power of two.
   always_ff @(posedge clk) begin
      if (rst) begin
         alloc_ptr <= '0;
         rel_ptr   <= '0;
         count     <= '0;
         state     <= RUN;
      end else begin
         if (alloc_gnt) alloc_ptr <= alloc_ptr + p_ptrwidth'(1);
         if (rel_valid) rel_ptr   <= rel_ptr + p_ptrwidth'(1);
         case ({alloc_gnt, rel_valid})
            2'b10:   count <= count + (p_ptrwidth+1)'(1);
            2'b01:   count <= count - (p_ptrwidth+1)'(1);
            default: count <= count;
         endcase
         state <= state_nxt;
      end
   end

   // DRAIN exits on the registered count, so drain_done trails the final retire by one cycle.
   always_comb begin
      state_nxt = state;
      case (state)
         RUN:     if (drain_req) state_nxt = DRAIN;
         DRAIN:   if (empty)     state_nxt = DONE;
         DONE:    state_nxt = RUN;
         default: state_nxt = RUN;
      endcase
   end

endmodule

// File: tb/tb_rob_sn_alloc.sv
// tb_rob_sn_alloc: scoreboard bench for rob_sn_alloc, depth-8 directed scenarios and depth-16 random traffic.
module tb_rob_sn_alloc;

`ifdef ROB_SN_ALLOC_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst = 1'b0;

   logic       req8 = 1'b0, rel8 = 1'b0, drn8 = 1'b0;
   logic       gnt8, empty8, full8, done8;
   logic [2:0] sn8, rsn8;
   logic [3:0] cnt8;

   logic       req16 = 1'b0, rel16 = 1'b0, drn16 = 1'b0;
   logic       gnt16, empty16, full16, done16;
   logic [3:0] sn16, rsn16;
   logic [4:0] cnt16;

   int n_checks = 0;
   int n_fail   = 0;

   logic [3:0] exp_q[$];
   logic [3:0] out_q[$];

   always #5 clk = ~clk;

   rob_sn_alloc #(.p_depth(8)) u_dut8 (
      .clk(clk), .rst(rst),
      .alloc_req(req8), .alloc_gnt(gnt8), .alloc_sn(sn8),
      .release_en(rel8), .release_sn(rsn8),
      .count(cnt8), .empty(empty8), .full(full8),
      .drain_req(drn8), .drain_done(done8)
   );

   rob_sn_alloc #(.p_depth(16)) u_dut16 (
      .clk(clk), .rst(rst),
      .alloc_req(req16), .alloc_gnt(gnt16), .alloc_sn(sn16),
      .release_en(rel16), .release_sn(rsn16),
      .count(cnt16), .empty(empty16), .full(full16),
      .drain_req(drn16), .drain_done(done16)
   );

   // Inputs change and outputs are sampled just after the falling edge.
   task automatic tick;
      @(negedge clk);
      #1;
   endtask

   task automatic do_reset;
      req8 = 0; rel8 = 0; drn8 = 0; req16 = 0; rel16 = 0; drn16 = 0;
      rst = 1;
      tick();
      rst = 0;
   endtask

   task automatic test_reset;
      do_reset();
      n_checks++; if (empty8 !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_empty: got %0d expected 1", empty8); end
      n_checks++; if (full8 !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_full: got %0d expected 0", full8); end
      n_checks++; if (cnt8 !== 4'd0) begin n_fail++; $display("[TB] FAIL reset_count: got %0d expected 0", cnt8); end
      n_checks++; if (gnt8 !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_gnt: got %0d expected 0", gnt8); end
      n_checks++; if (done8 !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_done: got %0d expected 0", done8); end
      n_checks++; if (sn8 !== 3'd0 || rsn8 !== 3'd0) begin n_fail++; $display("[TB] FAIL reset_ptrs: got %0d/%0d expected 0/0", sn8, rsn8); end
   endtask

   // Eight back-to-back grants in order, then the ninth is refused.
   task automatic test_fill;
      logic [3:0] e;
      for (int i = 0; i < 8; i++) begin
         exp_q.push_back(4'(i));
         req8 = 1; #1;
         e = exp_q.pop_front();
         n_checks++; if (gnt8 !== 1'b1) begin n_fail++; $display("[TB] FAIL fill_gnt%0d: got %0d expected 1", i, gnt8); end
         n_checks++; if (sn8 !== e[2:0]) begin n_fail++; $display("[TB] FAIL fill_sn%0d: got %0d expected %0d", i, sn8, e); end
         tick();
      end
      #1;
      n_checks++; if (full8 !== 1'b1) begin n_fail++; $display("[TB] FAIL fill_full: got %0d expected 1", full8); end
      n_checks++; if (cnt8 !== 4'd8) begin n_fail++; $display("[TB] FAIL fill_count: got %0d expected 8", cnt8); end
      n_checks++; if (gnt8 !== 1'b0) begin n_fail++; $display("[TB] FAIL fill_ninth_gnt: got %0d expected 0", gnt8); end
      req8 = 0;
   endtask

   task automatic test_release_wrap;
      rel8 = 1; #1;
      n_checks++; if (rsn8 !== 3'd0) begin n_fail++; $display("[TB] FAIL wrap_rsn_before: got %0d expected 0", rsn8); end
      tick();
      rel8 = 0; #1;
      n_checks++; if (rsn8 !== 3'd1) begin n_fail++; $display("[TB] FAIL wrap_rsn_after: got %0d expected 1", rsn8); end
      n_checks++; if (cnt8 !== 4'd7) begin n_fail++; $display("[TB] FAIL wrap_count: got %0d expected 7", cnt8); end
      req8 = 1; #1;
      n_checks++; if (gnt8 !== 1'b1) begin n_fail++; $display("[TB] FAIL wrap_gnt: got %0d expected 1", gnt8); end
      n_checks++; if (sn8 !== 3'd0) begin n_fail++; $display("[TB] FAIL wrap_sn: got %0d expected 0", sn8); end
      tick();
      req8 = 0;
   endtask

   task automatic test_full_release;
      do_reset();
      req8 = 1;
      repeat (8) tick();
      rel8 = 1; #1;
      n_checks++; if (gnt8 !== BYP) begin n_fail++; $display("[TB] FAIL bypass_gnt: got %0d expected %0d", gnt8, BYP); end
      n_checks++; if (sn8 !== 3'd0) begin n_fail++; $display("[TB] FAIL bypass_sn: got %0d expected 0", sn8); end
      tick();
      req8 = 0; rel8 = 0; #1;
      n_checks++; if (cnt8 !== (BYP ? 4'd8 : 4'd7)) begin n_fail++; $display("[TB] FAIL bypass_count: got %0d expected %0d", cnt8, BYP ? 8 : 7); end
      n_checks++; if (rsn8 !== 3'd1) begin n_fail++; $display("[TB] FAIL bypass_rsn: got %0d expected 1", rsn8); end
      n_checks++; if (sn8 !== (BYP ? 3'd1 : 3'd0)) begin n_fail++; $display("[TB] FAIL bypass_aptr: got %0d expected %0d", sn8, BYP ? 1 : 0); end
   endtask

   task automatic test_drain;
      do_reset();
      req8 = 1;
      repeat (3) tick();
      req8 = 0; drn8 = 1;
      tick();
      drn8 = 0; req8 = 1;
      for (int i = 0; i < 3; i++) begin
         rel8 = 1; #1;
         n_checks++; if (gnt8 !== 1'b0) begin n_fail++; $display("[TB] FAIL drain_gnt%0d: got %0d expected 0", i, gnt8); end
         n_checks++; if (done8 !== 1'b0) begin n_fail++; $display("[TB] FAIL drain_early_done%0d: got %0d expected 0", i, done8); end
         tick();
      end
      rel8 = 0; #1;
      n_checks++; if (cnt8 !== 4'd0) begin n_fail++; $display("[TB] FAIL drain_count: got %0d expected 0", cnt8); end
      n_checks++; if (done8 !== 1'b0 || gnt8 !== 1'b0) begin n_fail++; $display("[TB] FAIL drain_last: got done=%0d gnt=%0d expected 0/0", done8, gnt8); end
      tick();
      drn8 = 1; #1;
      n_checks++; if (done8 !== 1'b1) begin n_fail++; $display("[TB] FAIL drain_done: got %0d expected 1", done8); end
      n_checks++; if (gnt8 !== 1'b0) begin n_fail++; $display("[TB] FAIL drain_done_gnt: got %0d expected 0", gnt8); end
      tick();
      drn8 = 0; #1;
      n_checks++; if (done8 !== 1'b0) begin n_fail++; $display("[TB] FAIL drain_done_pulse: got %0d expected 0", done8); end
      n_checks++; if (gnt8 !== 1'b1) begin n_fail++; $display("[TB] FAIL drain_resume_gnt: got %0d expected 1", gnt8); end
      n_checks++; if (sn8 !== 3'd3) begin n_fail++; $display("[TB] FAIL drain_resume_sn: got %0d expected 3", sn8); end
      tick();
      req8 = 0;
   endtask

   task automatic test_empty;
      do_reset();
      rel8 = 1;
      tick();
      rel8 = 0; #1;
      n_checks++; if (cnt8 !== 4'd0) begin n_fail++; $display("[TB] FAIL empty_rel_count: got %0d expected 0", cnt8); end
      n_checks++; if (rsn8 !== 3'd0) begin n_fail++; $display("[TB] FAIL empty_rel_rsn: got %0d expected 0", rsn8); end
      drn8 = 1;
      tick();
      drn8 = 0; #1;
      n_checks++; if (done8 !== 1'b0) begin n_fail++; $display("[TB] FAIL empty_drain_c1: got %0d expected 0", done8); end
      tick();
      n_checks++; if (done8 !== 1'b1) begin n_fail++; $display("[TB] FAIL empty_drain_c2: got %0d expected 1", done8); end
      tick();
      n_checks++; if (done8 !== 1'b0) begin n_fail++; $display("[TB] FAIL empty_drain_c3: got %0d expected 0", done8); end
   endtask

   // In-order ROB model: grants push onto out_q, retires pop from the front.
   task automatic test_random;
      logic [3:0] m_next;
      bit         exp_rel, exp_gnt, dup;
      do_reset();
      out_q.delete();
      m_next = 4'd0;
      for (int c = 0; c < 1000; c++) begin
         if (c < 500) begin
            req16 = ($urandom_range(0, 3) != 0);
            rel16 = ($urandom_range(0, 2) == 0);
         end else begin
            req16 = ($urandom_range(0, 2) == 0);
            rel16 = ($urandom_range(0, 3) != 0);
         end
         #1;
         exp_rel = rel16 && (out_q.size() > 0);
         exp_gnt = req16 && ((out_q.size() < 16) || (BYP && exp_rel));
         n_checks++; if (gnt16 !== exp_gnt) begin n_fail++; $display("[TB] FAIL rand_gnt c%0d: got %0d expected %0d", c, gnt16, exp_gnt); end
         if (exp_rel) begin
            n_checks++; if (rsn16 !== out_q[0]) begin n_fail++; $display("[TB] FAIL rand_rsn c%0d: got %0d expected %0d", c, rsn16, out_q[0]); end
            void'(out_q.pop_front());
         end
         if (exp_gnt) begin
            n_checks++; if (sn16 !== m_next) begin n_fail++; $display("[TB] FAIL rand_sn c%0d: got %0d expected %0d", c, sn16, m_next); end
            dup = 1'b0;
            foreach (out_q[k]) if (out_q[k] == sn16) dup = 1'b1;
            n_checks++; if (dup) begin n_fail++; $display("[TB] FAIL rand_dup c%0d: got sn %0d still outstanding, expected unique", c, sn16); end
            out_q.push_back(m_next);
            m_next = m_next + 4'd1;
         end
         tick();
         n_checks++; if (cnt16 !== 5'(out_q.size())) begin n_fail++; $display("[TB] FAIL rand_count c%0d: got %0d expected %0d", c, cnt16, out_q.size()); end
      end
      req16 = 1; rel16 = 0;
      repeat (4) tick();
      req16 = 0; drn16 = 1;
      tick();
      drn16 = 0; req16 = 1; #1;
      n_checks++; if (gnt16 !== 1'b0) begin n_fail++; $display("[TB] FAIL middrain_gnt: got %0d expected 0", gnt16); end
      rst = 1;
      tick();
      rst = 0; req16 = 0; #1;
      n_checks++; if (cnt16 !== 5'd0 || empty16 !== 1'b1 || full16 !== 1'b0) begin n_fail++; $display("[TB] FAIL middrain_rst_count: got cnt=%0d empty=%0d full=%0d expected 0/1/0", cnt16, empty16, full16); end
      n_checks++; if (sn16 !== 4'd0 || rsn16 !== 4'd0) begin n_fail++; $display("[TB] FAIL middrain_rst_ptrs: got %0d/%0d expected 0/0", sn16, rsn16); end
      n_checks++; if (done16 !== 1'b0 || gnt16 !== 1'b0) begin n_fail++; $display("[TB] FAIL middrain_rst_outs: got done=%0d gnt=%0d expected 0/0", done16, gnt16); end
      req16 = 1; #1;
      n_checks++; if (gnt16 !== 1'b1) begin n_fail++; $display("[TB] FAIL middrain_rst_run: got %0d expected 1", gnt16); end
      req16 = 0;
   endtask

   initial begin
      test_reset();
      test_fill();
      test_release_wrap();
      test_full_release();
      test_drain();
      test_empty();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
